uop_queue: RTL and testbench
============================

// Module: uop_queue
// PURPOSE
//  Circular FIFO of 24-bit micro-ops between the 6502 instruction cracker and the rename/decode stage.
//  Accepts up to IN_W micro-ops per cycle and presents the WIDTH oldest as a lane window.
//  The decoder retires any leading prefix of that window each cycle.
//  Absorbs rename stalls (free pool/ROB exhaustion) without back-pressuring fetch every cycle.
// PARAMETERS
//  DEPTH  16  queue entries; power of 2, >= IN_W and >= WIDTH
//  IN_W   4   push lanes per cycle
//  WIDTH  4   output window lanes; equals decoder WIDTH
// PORTS
//  clk        in   1             clock; all state updates on rising edge
//  rst_n      in   1             asynchronous, active-low reset
//  flush      in   1             synchronous clear (branch mispredict / exception)
//  in_uops    in   IN_W*24       lane k = bits [24k +: 24]; lane 0 oldest
//  in_valid   in   IN_W          lane valid mask; only leading ones from bit 0 count
//  in_ready   out  1             queue can take a full IN_W group this cycle
//  out_uops   out  WIDTH*24      oldest WIDTH entries; lane 0 = head; [23:20] = opcode
//  out_valid  out  WIDTH         lane j valid iff j < count
//  out_taken  in   WIDTH         consumer accept mask; only leading ones ANDed with out_valid count
//  count      out  $clog2(DEPTH+1)  occupied entries (registered)
// BEHAVIOUR
//  - State: mem[DEPTH] x 24, head/tail ptrs ($clog2(DEPTH) bits, natural wrap), count register.
//  - Reset (rst_n low, async): head=tail=count=0; out_valid=0; out_uops=0; in_ready=1; mem contents don't-care.
//  - in_ready = (DEPTH - count) >= IN_W, computed from registered count only.
//    Same-cycle pops do not raise in_ready.
//  - n_push = 0 if !in_ready; else number of consecutive 1s in in_valid from bit 0.
//    Bits after the first 0 are ignored; 4'b1011 pushes 2.
//  - Pushed lane k is written to mem[tail+k]; tail += n_push.
//  - n_pop = number of consecutive j from 0 with out_taken[j] & out_valid[j].
//    A taken bit on an invalid lane, or after a gap, is ignored. head += n_pop.
//  - count_next = count + n_push - n_pop. Push and pop in the same cycle are both honoured.
//    Pushed entries become visible on out_* the cycle after the push (1-cycle latency); never same-cycle bypass.
//  - Output window is combinational from registered state:
//    out_uops lane j = mem[head+j] when j < count, else 24'h0.
//    out_valid[j] = (j < count).
//  - out_taken may depend combinationally on out_valid/out_uops. No combinational path from out_taken to in_ready/out_*.
//  - flush=1: next state head=tail=count=0. Same-cycle push and pop are discarded. Flush has priority over both.
//  - Full: count==DEPTH gives in_ready=0. count > DEPTH-IN_W also gives in_ready=0 (all-or-nothing group admission).
//  - Empty: count==0 gives out_valid=0; out_taken is ignored.
//  - Wrap: pointer arithmetic is mod DEPTH. A window/group straddling index DEPTH-1 -> 0 must be seamless.
//  - Reset asserted mid-operation: immediate clear regardless of clk. First push accepted on the first edge after rst_n rises.
//  - Assertions (sim only): count <= DEPTH.
// TESTING
//  1 Reset: rst_n=0 with in_valid=4'hF -> count=0, out_valid=0, in_ready=1; after release, next edge push 4 -> count=4.
//  2 Push then drain: push uops 0x100000..0x300003 (3 lanes, in_valid=4'b0111) -> next cycle out_valid=4'b0111, lane0=0x100000;
//    out_taken=4'b0011 -> count=1, lane0=0x300003.
//  3 Fill/back-pressure: DEPTH=16, push 4 groups of 4 -> count=16, in_ready=0.
//    Pop 2 + push attempt same cycle -> push rejected, count=14.
//    Next cycle in_ready=0 (14>12), then pop 2 -> in_ready=1.
//  4 Simultaneous push/pop at steady state: count=8, push 4, out_taken=4'hF -> count stays 8, FIFO order preserved across the tail.
//  5 Wrap-around: advance head/tail to 14, push 4 -> entries land in mem[14,15,0,1];
//    window lanes 0..3 show them in push order.
//  6 Flush with concurrent push+pop: count=6, flush=1, in_valid=4'hF, out_taken=4'hF -> count=0, out_valid=0 next cycle.
//    Gaps: in_valid=4'b1101 pushes 1; out_taken=4'b0110 pops 0.

Source files
------------

// File: rtl/uop_queue.sv
// uop_queue: circular FIFO of 24-bit micro-ops between the instruction cracker and rename.
// Accepts up to IN_W ops per cycle; presents the WIDTH oldest as a window the decoder retires a prefix of.
module uop_queue #(
    parameter int DEPTH = 16,
    parameter int IN_W  = 4,
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [IN_W*24-1:0]           in_uops,
    input  logic [IN_W-1:0]              in_valid,
    output logic                         in_ready,
    output logic [WIDTH*24-1:0]          out_uops,
    output logic [WIDTH-1:0]             out_valid,
    input  logic [WIDTH-1:0]             out_taken,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(IN_W+1);
    localparam int TW = $clog2(WIDTH+1);
    logic [23:0]     mem [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [PW-1:0]   n_push;
    logic [TW-1:0]   n_pop;
    logic [WIDTH-1:0] taken_ok;
    // Group admission is all-or-nothing and looks only at the registered count.
    assign in_ready = count <= CW'(DEPTH - IN_W);
    assign taken_ok = out_taken & out_valid;
    // Scanning from the top and clearing on every zero leaves the run length of ones from bit 0.
    always_comb begin
        n_push = '0;
        for (int k = IN_W - 1; k >= 0; k--) n_push = in_valid[k] ? n_push + PW'(1) : '0;
        n_push = in_ready ? n_push : '0;
    end
    always_comb begin
        n_pop = '0;
        for (int k = WIDTH - 1; k >= 0; k--) n_pop = taken_ok[k] ? n_pop + TW'(1) : '0;
    end
    always_comb begin
        out_valid = '0;
        out_uops  = '0;
        for (int j = 0; j < WIDTH; j++) begin
            out_valid[j]          = CW'(j) < count;
            out_uops[24*j +: 24]  = out_valid[j] ? mem[head + AW'(j)] : 24'h0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(n_pop);
            tail  <= tail + AW'(n_push);
            count <= count + CW'(n_push) - CW'(n_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (!flush)
            for (int k = 0; k < IN_W; k++)
                if (PW'(k) < n_push) mem[tail + AW'(k)] <= in_uops[24*k +: 24];
    end
    always_ff @(posedge clk) begin
        if (rst_n) assert (count <= CW'(DEPTH));
    end
endmodule

// File: tb/tb_uop_queue.sv
// tb_uop_queue: table vectors, hand sequences and random traffic against a queue-based reference model.
module tb_uop_queue;
    logic        clk = 0, rst_n = 0, flush = 0;
    logic [95:0] in_uops = '0;
    logic [3:0]  in_valid = '0, out_taken = '0;
    logic        in_ready;
    logic [95:0] out_uops;
    logic [3:0]  out_valid;
    logic [4:0]  count;
    int          total = 0, bad = 0;
    logic [23:0] q[$];

    typedef struct {
        logic        fl;
        logic [3:0]  iv;
        logic [95:0] iu;
        logic [3:0]  ot;
        int          ec;
        logic [3:0]  ev;
        logic [23:0] e0;
        logic        er;
    } vec_t;
    vec_t tv[10];

    uop_queue #(.DEPTH(16), .IN_W(4), .WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_uops(in_uops), .in_valid(in_valid),
        .in_ready(in_ready), .out_uops(out_uops), .out_valid(out_valid),
        .out_taken(out_taken), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(string nm, logic [95:0] act, logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int lead(logic [3:0] m);
        int n = 0;
        for (int k = 0; k < 4; k++) begin
            if (!m[k]) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [95:0] grp(int g);
        logic [95:0] r;
        for (int k = 0; k < 4; k++) r[24*k +: 24] = 24'(g * 24'h100000 + k);
        return r;
    endfunction

    // Drive one cycle of inputs, clock it, and advance the reference queue.
    task automatic step(logic fl, logic [3:0] iv, logic [95:0] iu, logic [3:0] ot);
        int np, npop;
        logic [3:0] vm;
        flush = fl; in_valid = iv; in_uops = iu; out_taken = ot;
        vm = '0;
        for (int j = 0; j < 4; j++) if (j < q.size()) vm[j] = 1'b1;
        np   = (16 - q.size() >= 4) ? lead(iv) : 0;
        npop = lead(ot & vm);
        @(posedge clk);
        #1;
        if (fl) q.delete();
        else begin
            repeat (npop) void'(q.pop_front());
            for (int k = 0; k < np; k++) q.push_back(iu[24*k +: 24]);
        end
    endtask

    task automatic model_check(string tag);
        logic [95:0] eu;
        logic [3:0]  ev;
        eu = '0; ev = '0;
        for (int j = 0; j < 4; j++)
            if (j < q.size()) begin
                ev[j] = 1'b1;
                eu[24*j +: 24] = q[j];
            end
        check({tag, ".count"}, count, q.size());
        check({tag, ".ready"}, in_ready, q.size() <= 12);
        check({tag, ".valid"}, out_valid, ev);
        check({tag, ".uops"}, out_uops, eu);
    endtask

    initial begin
        tv[0] = '{0, 4'b0111, {24'h400004, 24'h300003, 24'h200001, 24'h100000}, 4'b0000, 3, 4'b0111, 24'h100000, 1};
        tv[1] = '{0, 4'b0000, '0, 4'b0011, 1, 4'b0001, 24'h300003, 1};
        tv[2] = '{0, 4'b1101, grp(10), 4'b0110, 2, 4'b0011, 24'h300003, 1};
        tv[3] = '{1, 4'b1111, grp(11), 4'b1111, 0, 4'b0000, 24'h000000, 1};
        tv[4] = '{0, 4'b1111, grp(5), 4'b1111, 4, 4'b1111, 24'h500000, 1};
        tv[5] = '{0, 4'b1111, grp(6), 4'b0000, 8, 4'b1111, 24'h500000, 1};
        tv[6] = '{0, 4'b1111, grp(7), 4'b0000, 12, 4'b1111, 24'h500000, 1};
        tv[7] = '{0, 4'b1111, grp(8), 4'b0000, 16, 4'b1111, 24'h500000, 0};
        tv[8] = '{0, 4'b1111, grp(9), 4'b0011, 14, 4'b1111, 24'h500002, 0};
        tv[9] = '{0, 4'b0000, '0, 4'b0011, 12, 4'b1111, 24'h600000, 1};

        in_valid = 4'hF;
        in_uops  = grp(1);
        repeat (2) @(posedge clk);
        #1;
        check("rst.count", count, 0);
        check("rst.valid", out_valid, 0);
        check("rst.ready", in_ready, 1);
        check("rst.uops", out_uops, 0);
        rst_n = 1;
        step(0, 4'hF, grp(1), 4'h0);
        check("rst.first_push", count, 4);
        step(1, 4'h0, '0, 4'h0);
        check("flush.count", count, 0);

        for (int i = 0; i < 10; i++) begin
            step(tv[i].fl, tv[i].iv, tv[i].iu, tv[i].ot);
            check($sformatf("vec%0d.count", i), count, tv[i].ec);
            check($sformatf("vec%0d.valid", i), out_valid, tv[i].ev);
            check($sformatf("vec%0d.lane0", i), out_uops[23:0], tv[i].e0);
            check($sformatf("vec%0d.ready", i), in_ready, tv[i].er);
        end

        // Walk head/tail to 14 so the next group straddles the end of the array.
        step(1, 4'h0, '0, 4'h0);
        step(0, 4'b0011, grp(2), 4'b0011);
        for (int i = 0; i < 6; i++) step(0, 4'b0011, grp(3 + i), 4'b0011);
        step(0, 4'h0, '0, 4'b0011);
        check("wrap.empty", count, 0);
        step(0, 4'hF, grp(12), 4'h0);
        check("wrap.uops", out_uops, grp(12));
        check("wrap.valid", out_valid, 4'hF);
        model_check("wrap");
        step(0, 4'hF, grp(13), 4'h0);
        step(0, 4'hF, grp(14), 4'hF);
        check("steady.count", count, 8);
        check("steady.uops", out_uops, grp(13));
        model_check("steady");

        for (int i = 0; i < 400; i++) begin
            logic [95:0] u;
            u = {$urandom, $urandom, $urandom};
            step($urandom_range(0, 31) == 0, 4'($urandom), u,
                 $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom));
            model_check($sformatf("rnd%0d", i));
        end

        step(0, 4'hF, grp(5), 4'h0);
        #2 rst_n = 0;
        #1;
        q.delete();
        check("midrst.count", count, 0);
        check("midrst.valid", out_valid, 0);
        check("midrst.ready", in_ready, 1);
        rst_n = 1;
        step(0, 4'hF, grp(6), 4'h0);
        check("midrst.push", count, 4);
        model_check("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
